max_pool_collector: RTL and testbench

Downstream stage of the 2x2 pooling line buffer. Each 4-pixel window it emits is reduced to one pooled bit (binary max = OR). The block collects the pooled feature map (13x13 for a 26x26 input) into a ping-pong frame store, then streams it bit-serially, in raster order, to the fully-connected layer over a valid/ready handshake. Collection of frame N+1 overlaps draining of frame N.

---
 rtl/max_pool_collector_pkg.sv | 26 ++
 rtl/max_pool_collector_frame_bank.sv | 26 ++
 rtl/max_pool_collector.sv | 135 +++++++++++++
 tb/tb_max_pool_collector.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/max_pool_collector_pkg.sv
// Shared constants for the 2x2 max-pool collector and the FC layer that consumes its output.
// Pooled-map geometry is derived from the conv-map size feeding the line buffer.
package max_pool_collector_pkg;

    localparam int DEF_IN_WIDTH  = 26;
    localparam int DEF_IN_HEIGHT = 26;
    localparam int OUT_W         = DEF_IN_WIDTH / 2;
    localparam int OUT_H         = DEF_IN_HEIGHT / 2;
    localparam int OUT_N         = OUT_W * OUT_H;
    localparam int IDX_BITS      = $clog2(OUT_N);
    localparam int BANK_SEL_W    = 1;

    function automatic int out_n_f(input int in_w, input int in_h);
        return (in_w / 2) * (in_h / 2);
    endfunction

    function automatic int idx_bits_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Binary max over a 2x2 window is a plain OR.
    function automatic logic pool_max(input logic [3:0] win);
        return |win;
    endfunction

endpackage

// File: rtl/max_pool_collector_frame_bank.sv
// One pooled-frame bank: single write port, asynchronous read port.
// Contents are never reset; validity is tracked by the collector's full flags.
module pool_frame_bank #(
    parameter int DEPTH = 169,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic          wdata,
    input  logic [AW-1:0] raddr,
    output logic          rdata
);

    logic [DEPTH-1:0] mem_r;

    // Bit write, ignoring addresses beyond the frame.
    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < DEPTH)) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = (int'(raddr) < DEPTH) ? mem_r[raddr] : 1'b0;

endmodule

// File: rtl/max_pool_collector.sv
// Collects 2x2-pooled bits into a ping-pong frame store and streams each completed
// frame bit-serially in raster order over a valid/ready handshake.
module max_pool_collector
    import max_pool_collector_pkg::*;
#(
    parameter  int IN_WIDTH  = DEF_IN_WIDTH,
    parameter  int IN_HEIGHT = DEF_IN_HEIGHT,
    localparam int PIX_N     = out_n_f(IN_WIDTH, IN_HEIGHT),
    localparam int AW        = idx_bits_f(PIX_N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  logic          pixel_0,
    input  logic          pixel_1,
    input  logic          pixel_2,
    input  logic          pixel_3,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_bit,
    output logic [AW-1:0] out_index,
    output logic          out_last,
    output logic          frame_done,
    output logic          overflow
);

    localparam logic [AW-1:0] LAST_IDX = AW'(PIX_N - 1);

    logic [1:0]            full_r, full_nxt_s;
    logic [BANK_SEL_W-1:0] wr_bank_r, wr_bank_nxt_s, rd_bank_r, rd_bank_nxt_s;
    logic [AW-1:0]         wr_cnt_r, wr_cnt_nxt_s, rd_cnt_r, rd_cnt_nxt_s;
    logic                  out_valid_r, out_bit_r, out_last_r, frame_done_r, overflow_r;
    logic                  wr_fire_s, wr_done_s, rd_fire_s, rd_done_s, drop_s;
    logic                  pool_bit_s, rd_bit_s, out_valid_nxt_s, out_last_nxt_s;
    logic [1:0]            bank_we_s, bank_rdata_s;

    assign pool_bit_s = pool_max({pixel_3, pixel_2, pixel_1, pixel_0});

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_we_s[b] = wr_fire_s & (wr_bank_r == BANK_SEL_W'(b));

        pool_frame_bank #(
            .DEPTH (PIX_N),
            .AW    (AW)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we_s[b]),
            .waddr (wr_cnt_r),
            .wdata (pool_bit_s),
            .raddr (rd_cnt_nxt_s),
            .rdata (bank_rdata_s[b])
        );
    end

    // Write/read pointer and full-flag next state; write-complete and read-complete never hit the same bank.
    always_comb begin
        wr_fire_s     = valid_in & ~full_r[wr_bank_r];
        drop_s        = valid_in & full_r[wr_bank_r];
        wr_done_s     = wr_fire_s & (wr_cnt_r == LAST_IDX);
        rd_fire_s     = out_valid_r & out_ready;
        rd_done_s     = rd_fire_s & (rd_cnt_r == LAST_IDX);
        full_nxt_s    = full_r;
        wr_bank_nxt_s = wr_bank_r;
        wr_cnt_nxt_s  = wr_cnt_r;
        rd_bank_nxt_s = rd_bank_r;
        rd_cnt_nxt_s  = rd_cnt_r;

        if (wr_done_s) begin
            full_nxt_s[wr_bank_r] = 1'b1;
            wr_bank_nxt_s         = ~wr_bank_r;
            wr_cnt_nxt_s          = '0;
        end else if (wr_fire_s) begin
            wr_cnt_nxt_s = wr_cnt_r + AW'(1);
        end else begin
            wr_cnt_nxt_s = wr_cnt_r;
        end

        if (rd_done_s) begin
            full_nxt_s[rd_bank_r] = 1'b0;
            rd_bank_nxt_s         = ~rd_bank_r;
            rd_cnt_nxt_s          = '0;
        end else if (rd_fire_s) begin
            rd_cnt_nxt_s = rd_cnt_r + AW'(1);
        end else begin
            rd_cnt_nxt_s = rd_cnt_r;
        end

        out_valid_nxt_s = full_nxt_s[rd_bank_nxt_s];
        out_last_nxt_s  = out_valid_nxt_s & (rd_cnt_nxt_s == LAST_IDX);
    end

    // Next presented bit, forwarding a same-cycle write to the location about to be shown.
    always_comb begin
        if (wr_fire_s && (wr_bank_r == rd_bank_nxt_s) && (wr_cnt_r == rd_cnt_nxt_s)) begin
            rd_bit_s = pool_bit_s;
        end else begin
            rd_bit_s = bank_rdata_s[rd_bank_nxt_s];
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r       <= 2'b00;
            wr_bank_r    <= '0;
            wr_cnt_r     <= '0;
            rd_bank_r    <= '0;
            rd_cnt_r     <= '0;
            out_valid_r  <= 1'b0;
            out_bit_r    <= 1'b0;
            out_last_r   <= 1'b0;
            frame_done_r <= 1'b0;
            overflow_r   <= 1'b0;
        end else begin
            full_r       <= full_nxt_s;
            wr_bank_r    <= wr_bank_nxt_s;
            wr_cnt_r     <= wr_cnt_nxt_s;
            rd_bank_r    <= rd_bank_nxt_s;
            rd_cnt_r     <= rd_cnt_nxt_s;
            out_valid_r  <= out_valid_nxt_s;
            out_bit_r    <= out_valid_nxt_s ? rd_bit_s : 1'b0;
            out_last_r   <= out_last_nxt_s;
            frame_done_r <= wr_done_s;
            overflow_r   <= overflow_r | drop_s;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_bit    = out_bit_r;
    assign out_index  = rd_cnt_r;
    assign out_last   = out_last_r;
    assign frame_done = frame_done_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_max_pool_collector.sv
// Randomized bench for max_pool_collector against a frame-queue reference model.
module tb_max_pool_collector;

    localparam int W  = 26;
    localparam int H  = 26;
    localparam int N  = (W / 2) * (H / 2);
    localparam int AW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst, valid_in, pixel_0, pixel_1, pixel_2, pixel_3, out_ready;
    logic          out_valid, out_bit, out_last, frame_done, overflow;
    logic [AW-1:0] out_index;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: completed frames awaiting/under drain, plus the frame being collected.
    logic [N-1:0] frames_q[$];
    logic [N-1:0] cur_frame;
    int           cur_cnt = 0;
    int           rd_pos  = 0;
    logic         m_ovf   = 1'b0;
    logic         m_fd    = 1'b0;

    always #5 clk = ~clk;

    max_pool_collector #(
        .IN_WIDTH  (W),
        .IN_HEIGHT (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .pixel_0    (pixel_0),
        .pixel_1    (pixel_1),
        .pixel_2    (pixel_2),
        .pixel_3    (pixel_3),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_bit    (out_bit),
        .out_index  (out_index),
        .out_last   (out_last),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic ready_for(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return ((c % 4) == 0) || ((c % 4) == 3);
            2:       return 1'b0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    function automatic logic [3:0] pix_for(input int mode, input int i);
        case (mode)
            0:       return ((i % 3) == 0) ? 4'(1 << (i % 4)) : 4'b0000;
            1:       return ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            default: return 4'b1111;
        endcase
    endfunction

    task automatic step(input logic v, input logic [3:0] px, input logic rdy, input logic r);
        int   pre_size;
        logic exp_valid;
        valid_in = v;
        {pixel_3, pixel_2, pixel_1, pixel_0} = px;
        out_ready = rdy;
        rst = r;
        @(posedge clk);
        cyc++;
        if (r) begin
            frames_q.delete();
            cur_cnt = 0;
            rd_pos  = 0;
            m_ovf   = 1'b0;
            m_fd    = 1'b0;
        end else begin
            pre_size = frames_q.size();
            m_fd     = 1'b0;
            if (rdy && pre_size > 0) begin
                if (rd_pos == N - 1) begin
                    void'(frames_q.pop_front());
                    rd_pos = 0;
                end else begin
                    rd_pos++;
                end
            end
            if (v) begin
                if (pre_size == 2) begin
                    m_ovf = 1'b1;
                end else begin
                    cur_frame[cur_cnt] = |px;
                    if (cur_cnt == N - 1) begin
                        frames_q.push_back(cur_frame);
                        cur_cnt = 0;
                        m_fd    = 1'b1;
                    end else begin
                        cur_cnt++;
                    end
                end
            end
        end
        #1;
        exp_valid = (frames_q.size() > 0);
        check_eq("out_valid", 32'(out_valid), 32'(exp_valid));
        check_eq("out_index", 32'(out_index), 32'(rd_pos));
        check_eq("out_last", 32'(out_last), 32'(exp_valid && rd_pos == N - 1));
        check_eq("frame_done", 32'(frame_done), 32'(m_fd));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        if (exp_valid) begin
            check_eq("out_bit", 32'(out_bit), 32'(frames_q[0][rd_pos]));
        end else if (r) begin
            check_eq("out_bit_rst", 32'(out_bit), 32'd0);
        end
    endtask

    task automatic send_windows(input int count, input int pmode, input int rmode, input int gap_pct);
        for (int i = 0; i < count; i++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                step(1'b0, 4'b0000, ready_for(rmode, cyc), 1'b0);
            end
            step(1'b1, pix_for(pmode, i % N), ready_for(rmode, cyc), 1'b0);
        end
    endtask

    task automatic drain(input int rmode);
        for (int k = 0; k < 8 * N && frames_q.size() > 0; k++) begin
            step(1'b0, 4'b0000, ready_for(rmode, cyc), 1'b0);
        end
        step(1'b0, 4'b0000, ready_for(rmode, cyc), 1'b0);
        check_eq("drained_idle", 32'(out_valid), 32'd0);
    endtask

    initial begin
        valid_in  = 1'b0;
        {pixel_3, pixel_2, pixel_1, pixel_0} = 4'b0000;
        out_ready = 1'b0;
        rst       = 1'b1;
        repeat (3) step(1'b0, 4'b0000, 1'b0, 1'b1);

        send_windows(N, 0, 0, 0);          // patterned single frame
        drain(0);
        send_windows(N, 1, 1, 0);          // 1,0,0,1 backpressure
        drain(1);
        send_windows(2 * N, 1, 0, 0);      // back-to-back overlap
        drain(0);
        send_windows(N, 2, 0, 0);          // all ones
        drain(0);
        send_windows(3 * N, 1, 2, 0);      // both banks full, third frame dropped
        check_eq("overflow_set", 32'(overflow), 32'd1);
        drain(0);
        send_windows(50, 1, 0, 0);         // reset mid-frame
        step(1'b1, 4'b1111, 1'b1, 1'b1);
        step(1'b0, 4'b0000, 1'b1, 1'b1);
        send_windows(N, 1, 0, 0);
        drain(0);
        repeat (3) begin
            send_windows(2 * N, 1, 3, 30);
            drain(3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
